register_array_pq: RTL and testbench

Sorted register-array priority queue with explicit per-slot valid bits, a key/payload split, selectable max-first or min-first ordering and a synchronous flush. It is the parametrised successor to the zero-as-empty register array: keys of value zero are legal, and enqueue is always available. Every cycle the head slot holds the highest-priority live entry. It sits between a scheduler front end and downstream consumers that pop one entry per cycle.

---
 rtl/register_array_pq_pkg.sv | 24 ++
 rtl/register_array_pq_cmp.sv | 26 ++
 rtl/register_array_pq.sv | 227 ++++++++++++++++++++++
 tb/tb_register_array_pq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_array_pq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : register_array_pq_pkg
//  Brief    : Shared types and helpers for the register-array priority queue.
//  Revision : 1.0 - initial release
// ============================================================================
package register_array_pq_pkg;

    // Operation selected for the current cycle, after priority decode
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_FLUSH   = 3'd4
    } op_e;

    // Width needed to hold a count of 0..depth
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_array_pq_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : register_array_pq_cmp
//  Brief    : Per-slot "stays ahead" compare: slot is live and its key beats
//             or equals the incoming key. Ties keep the existing entry ahead,
//             which gives FIFO order among equal keys.
//  Revision : 1.0 - initial release
// ============================================================================
module register_array_pq_cmp #(
    parameter int KEY_WIDTH = 16,
    parameter int MAX_FIRST = 1
) (
    input  logic [KEY_WIDTH-1:0] i_slot_key,
    input  logic                 i_slot_valid,
    input  logic [KEY_WIDTH-1:0] i_new_key,
    output logic                 o_ahead
);

    if (MAX_FIRST != 0) begin : g_max
        assign o_ahead = i_slot_valid && (i_slot_key >= i_new_key);
    end else begin : g_min
        assign o_ahead = i_slot_valid && (i_slot_key <= i_new_key);
    end

endmodule
`default_nettype wire

// File: rtl/register_array_pq.sv
`default_nettype none
// ============================================================================
//  Module   : register_array_pq
//  Brief    : Sorted register-array priority queue with per-slot valid bits,
//             key/payload split, max- or min-first ordering and flush.
//             Slot 0 always holds the highest-priority live entry.
//  Options  : REGISTER_ARRAY_PQ_STATS_EN adds o_peak (count high-water mark).
//  Revision : 1.0 - initial release
// ============================================================================
module register_array_pq
    import register_array_pq_pkg::*;
#(
    parameter int QUEUE_SIZE = 8,
    parameter int KEY_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FIRST  = 1
) (
    input  logic                              i_CLK,
    input  logic                              i_RSTn,
    input  logic                              i_flush,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic [KEY_WIDTH-1:0]              i_key,
    input  logic [DATA_WIDTH-1:0]             i_data,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
    output logic [KEY_WIDTH-1:0]              o_key,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic                              o_drop
`ifdef REGISTER_ARRAY_PQ_STATS_EN
    ,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_peak
`endif
);

    localparam int c_CNT_W = cnt_w(QUEUE_SIZE);

    logic                  valid_q [QUEUE_SIZE];
    logic                  valid_d [QUEUE_SIZE];
    logic [KEY_WIDTH-1:0]  key_q   [QUEUE_SIZE];
    logic [KEY_WIDTH-1:0]  key_d   [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] data_q  [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] data_d  [QUEUE_SIZE];
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic                  drop_q, drop_d;

    logic [QUEUE_SIZE-1:0] w_ahead;
    logic [c_CNT_W-1:0]    w_pos_push;
    logic [c_CNT_W-1:0]    w_pos_repl;
    logic                  w_full, w_empty;
    op_e                   w_op;

    assign w_full  = (count_q == c_CNT_W'(QUEUE_SIZE));
    assign w_empty = (count_q == '0);

    // Thermometer of slots that stay ahead of the incoming key
    for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_cmp
        register_array_pq_cmp #(
            .KEY_WIDTH (KEY_WIDTH),
            .MAX_FIRST (MAX_FIRST)
        ) u_cmp (
            .i_slot_key   (key_q[i]),
            .i_slot_valid (valid_q[i]),
            .i_new_key    (i_key),
            .o_ahead      (w_ahead[i])
        );
    end

    // Insert position = population of the thermometer; for a replace the head
    // leaves first, so slot 0's contribution is removed (thermometer shape
    // guarantees slot 0 is set whenever any other slot is).
    always_comb begin
        w_pos_push = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            w_pos_push = w_pos_push + c_CNT_W'(w_ahead[i]);
        end
        w_pos_repl = w_pos_push - c_CNT_W'(w_ahead[0]);
    end

    // Priority decode; no-op cases (pop empty, push full) collapse to idle
    always_comb begin
        w_op   = OP_IDLE;
        drop_d = 1'b0;
        if (i_flush) begin
            w_op = OP_FLUSH;
        end else if (i_push && i_pop) begin
            w_op = w_empty ? OP_PUSH : OP_REPLACE;
        end else if (i_push) begin
            if (w_full) drop_d = 1'b1;
            else        w_op   = OP_PUSH;
        end else if (i_pop) begin
            if (!w_empty) w_op = OP_POP;
        end
    end

    // Per-slot shift/insert mux
    for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_slot
        logic                  prv_v, nxt_v;
        logic [KEY_WIDTH-1:0]  prv_k, nxt_k;
        logic [DATA_WIDTH-1:0] prv_d, nxt_d;
        logic                  v_d;
        logic [KEY_WIDTH-1:0]  k_d;
        logic [DATA_WIDTH-1:0] d_d;

        if (i == 0) begin : g_bot
            assign prv_v = 1'b0;
            assign prv_k = '0;
            assign prv_d = '0;
        end else begin : g_prv
            assign prv_v = valid_q[i-1];
            assign prv_k = key_q[i-1];
            assign prv_d = data_q[i-1];
        end

        if (i == QUEUE_SIZE - 1) begin : g_top
            assign nxt_v = 1'b0;
            assign nxt_k = '0;
            assign nxt_d = '0;
        end else begin : g_nxt
            assign nxt_v = valid_q[i+1];
            assign nxt_k = key_q[i+1];
            assign nxt_d = data_q[i+1];
        end

        // Select the next content of this slot from hold/neighbour/new entry
        always_comb begin
            v_d = valid_q[i];
            k_d = key_q[i];
            d_d = data_q[i];
            unique case (w_op)
                OP_FLUSH: begin
                    v_d = 1'b0;
                    k_d = '0;
                    d_d = '0;
                end
                OP_PUSH: begin
                    if (c_CNT_W'(i) == w_pos_push) begin
                        v_d = 1'b1;
                        k_d = i_key;
                        d_d = i_data;
                    end else if (c_CNT_W'(i) > w_pos_push) begin
                        v_d = prv_v;
                        k_d = prv_k;
                        d_d = prv_d;
                    end
                end
                OP_POP: begin
                    v_d = nxt_v;
                    k_d = nxt_k;
                    d_d = nxt_d;
                end
                OP_REPLACE: begin
                    if (c_CNT_W'(i) < w_pos_repl) begin
                        v_d = nxt_v;
                        k_d = nxt_k;
                        d_d = nxt_d;
                    end else if (c_CNT_W'(i) == w_pos_repl) begin
                        v_d = 1'b1;
                        k_d = i_key;
                        d_d = i_data;
                    end
                end
                default: ;
            endcase
        end

        assign valid_d[i] = v_d;
        assign key_d[i]   = k_d;
        assign data_d[i]  = d_d;
    end

    // Live-entry counter
    always_comb begin
        count_d = count_q;
        unique case (w_op)
            OP_FLUSH: count_d = '0;
            OP_PUSH:  count_d = count_q + 1'b1;
            OP_POP:   count_d = count_q - 1'b1;
            default:  ;
        endcase
    end

    // State registers
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                valid_q[i] <= 1'b0;
                key_q[i]   <= '0;
                data_q[i]  <= '0;
            end
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                valid_q[i] <= valid_d[i];
                key_q[i]   <= key_d[i];
                data_q[i]  <= data_d[i];
            end
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

`ifdef REGISTER_ARRAY_PQ_STATS_EN
    logic [c_CNT_W-1:0] peak_q, peak_d;

    assign peak_d = (count_d > peak_q) ? count_d : peak_q;

    // High-water mark of count; only reset clears it
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) peak_q <= '0;
        else         peak_q <= peak_d;
    end

    assign o_peak = peak_q;
`endif

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = count_q;
    assign o_key   = valid_q[0] ? key_q[0]  : '0;
    assign o_data  = valid_q[0] ? data_q[0] : '0;
    assign o_drop  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_register_array_pq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_array_pq
//  Brief    : Self-checking bench. Two 4-slot instances (max-first and
//             min-first) share stimulus; a sorted-list model per instance
//             queues expected head/count/drop, compared after each edge.
//  Options  : REGISTER_ARRAY_PQ_STATS_EN also checks o_peak.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_array_pq;

    localparam int QS = 4;
    localparam int KW = 16;
    localparam int DW = 16;
    localparam int CW = $clog2(QS + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, push, pop;
    logic [KW-1:0] key;
    logic [DW-1:0] data;

    logic          full  [2];
    logic          empty [2];
    logic          drop  [2];
    logic [CW-1:0] cnt   [2];
    logic [KW-1:0] okey  [2];
    logic [DW-1:0] odata [2];
`ifdef REGISTER_ARRAY_PQ_STATS_EN
    logic [CW-1:0] peak  [2];
`endif

    always #5 clk = ~clk;

    // Instance 0: max-first; instance 1: min-first
    for (genvar d = 0; d < 2; d++) begin : g_dut
        register_array_pq #(
            .QUEUE_SIZE (QS),
            .KEY_WIDTH  (KW),
            .DATA_WIDTH (DW),
            .MAX_FIRST  (1 - d)
        ) u_dut (
            .i_CLK   (clk),
            .i_RSTn  (rst_n),
            .i_flush (flush),
            .i_push  (push),
            .i_pop   (pop),
            .i_key   (key),
            .i_data  (data),
            .o_full  (full[d]),
            .o_empty (empty[d]),
            .o_count (cnt[d]),
            .o_key   (okey[d]),
            .o_data  (odata[d]),
            .o_drop  (drop[d])
`ifdef REGISTER_ARRAY_PQ_STATS_EN
            ,
            .o_peak  (peak[d])
`endif
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: sorted lists with stable insertion
    int mk [2][QS];
    int md [2][QS];
    int mc [2];
    int mpeak [2];

    typedef struct {
        int d;
        int key;
        int data;
        int cnt;
        bit drop;
        int peak;
    } exp_t;
    exp_t sbq [$];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
        end
    endtask

    function automatic bit beats(input int d, input int a, input int b);
        return (d == 0) ? (a > b) : (a < b);
    endfunction

    // Append at the tail, then bubble toward the head only past strictly
    // worse entries, so equal keys keep arrival order
    task automatic model_push(input int d, input int k, input int dt);
        int j;
        j = mc[d];
        mk[d][j] = k;
        md[d][j] = dt;
        mc[d]++;
        while (j > 0 && beats(d, k, mk[d][j-1])) begin
            mk[d][j] = mk[d][j-1];
            md[d][j] = md[d][j-1];
            mk[d][j-1] = k;
            md[d][j-1] = dt;
            j--;
        end
    endtask

    task automatic model_pop(input int d);
        for (int j = 0; j < mc[d] - 1; j++) begin
            mk[d][j] = mk[d][j+1];
            md[d][j] = md[d][j+1];
        end
        mc[d]--;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mc[d] = 0;
            mpeak[d] = 0;
        end
        sbq.delete();
    endtask

    // One cycle of stimulus: drive, model, queue expectations, then compare
    task automatic step(input bit f, input bit pu, input bit po, input int k, input int dt);
        exp_t e;
        @(negedge clk);
        flush = f;
        push  = pu;
        pop   = po;
        key   = KW'(k);
        data  = DW'(dt);
        for (int d = 0; d < 2; d++) begin
            e.drop = 1'b0;
            if (f) begin
                mc[d] = 0;
            end else if (pu && po) begin
                if (mc[d] > 0) model_pop(d);
                model_push(d, k, dt);
            end else if (pu) begin
                if (mc[d] == QS) e.drop = 1'b1;
                else             model_push(d, k, dt);
            end else if (po) begin
                if (mc[d] > 0) model_pop(d);
            end
            if (mc[d] > mpeak[d]) mpeak[d] = mc[d];
            e.d    = d;
            e.key  = (mc[d] > 0) ? mk[d][0] : 0;
            e.data = (mc[d] > 0) ? md[d][0] : 0;
            e.cnt  = mc[d];
            e.peak = mpeak[d];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("head_key",  e.d, 32'(okey[e.d]),  e.key);
            chk("head_data", e.d, 32'(odata[e.d]), e.data);
            chk("count",     e.d, 32'(cnt[e.d]),   e.cnt);
            chk("drop",      e.d, 32'(drop[e.d]),  32'(e.drop));
            chk("empty",     e.d, 32'(empty[e.d]), 32'(e.cnt == 0));
            chk("full",      e.d, 32'(full[e.d]),  32'(e.cnt == QS));
`ifdef REGISTER_ARRAY_PQ_STATS_EN
            chk("peak",      e.d, 32'(peak[e.d]),  e.peak);
`endif
        end
    endtask

    task automatic chk_cleared(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_key"},   d, 32'(okey[d]),  0);
            chk({tag, "_data"},  d, 32'(odata[d]), 0);
            chk({tag, "_count"}, d, 32'(cnt[d]),   0);
            chk({tag, "_empty"}, d, 32'(empty[d]), 1);
            chk({tag, "_full"},  d, 32'(full[d]),  0);
            chk({tag, "_drop"},  d, 32'(drop[d]),  0);
`ifdef REGISTER_ARRAY_PQ_STATS_EN
            chk({tag, "_peak"},  d, 32'(peak[d]),  0);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int push_keys [4];
        int push_data [4];
        int heads0    [4];
        int pop_keys  [4];
        int pop_data  [4];

        push_keys = '{5, 9, 1, 9};
        push_data = '{'hA, 'hB, 'hC, 'hD};
        heads0    = '{5, 9, 9, 9};
        pop_keys  = '{9, 5, 1, 0};
        pop_data  = '{'hD, 'hA, 'hC, 0};

        rst_n = 1'b0;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        key   = '0;
        data  = '0;
        model_reset();

        // Reset state
        #12;
        chk_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ordering and drain (max-first instance: explicit constants)
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, push_keys[i], push_data[i]);
            chk("ord_head", 0, 32'(okey[0]), heads0[i]);
        end
        chk("ord_count", 0, 32'(cnt[0]), 4);
        chk("ord_top_data", 0, 32'(odata[0]), 'hB);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            chk("drain_key",  0, 32'(okey[0]),  pop_keys[i]);
            chk("drain_data", 0, 32'(odata[0]), pop_data[i]);
        end
        chk("drain_empty", 0, 32'(empty[0]), 1);

        // Full and drop
        step(0, 1, 0, 3, 'h31);
        step(0, 1, 0, 8, 'h32);
        step(0, 1, 0, 1, 'h33);
        step(0, 1, 0, 6, 'h34);
        step(0, 1, 0, 7, 'h35);
        chk("full_drop",  0, 32'(drop[0]), 1);
        chk("full_full",  0, 32'(full[0]), 1);
        chk("full_head",  0, 32'(okey[0]), 8);
        step(0, 0, 0, 0, 0);
        chk("drop_once",  0, 32'(drop[0]), 0);
        step(0, 1, 1, 7, 'h36);
        chk("repl_count", 0, 32'(cnt[0]), 4);
        chk("repl_head",  0, 32'(okey[0]), 7);

        // Empty edge cases
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("pop_empty_drop",  0, 32'(drop[0]), 0);
        chk("pop_empty_count", 0, 32'(cnt[0]), 0);
        step(0, 1, 1, 0, 'h55);
        chk("repl_empty_empty", 1, 32'(empty[1]), 0);
        chk("repl_empty_key",   1, 32'(okey[1]), 0);
        chk("repl_empty_count", 1, 32'(cnt[1]), 1);

        // Min ordering and flush
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 3, 1);
        step(0, 1, 0, 2, 2);
        step(0, 1, 0, 8, 3);
        chk("min_head", 1, 32'(okey[1]), 2);
        step(1, 1, 0, 1, 4);
        chk("flush_count", 1, 32'(cnt[1]), 0);
        chk("flush_drop",  1, 32'(drop[1]), 0);

        // Asynchronous reset between clock edges during pushes
        step(0, 1, 0, 4, 1);
        step(0, 1, 0, 2, 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        #1;
        model_reset();
        chk_cleared("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 6, 'h66);
        chk("post_rst_head", 0, 32'(okey[0]), 6);

        // Random stream against the model
        for (int n = 0; n < 10000; n++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if (r == 0) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            else        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
